// File: rtl/cpsr_unit.sv
// Program status state: committed CPSR plus one banked SPSR per exception mode.
// Exactly one event per cycle, priority exc_req > exc_return > msr > flag update.
module cpsr_unit (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_execute_en,
    input  logic        in_flag_we,
    input  logic [3:0]  in_alu_flags,
    input  logic [3:0]  in_flag_mask,
    input  logic        in_msr_we,
    input  logic        in_msr_spsr,
    input  logic [1:0]  in_msr_field,
    input  logic [31:0] in_msr_data,
    input  logic        in_exc_req,
    input  logic [4:0]  in_exc_mode,
    input  logic        in_exc_return,
    output logic [31:0] out_cpsr,
    output logic [3:0]  out_flags,
    output logic [31:0] out_spsr,
    output logic        out_priv
);

    localparam int unsigned MODE_W = 5;
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned SPSR_W = 12;
    localparam int unsigned BANK_N = 5;
    localparam int unsigned IDX_W  = 3;

    localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
    localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
    localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
    localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
    localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
    localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
    localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

    function automatic logic is_exc_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
               (m == MODE_ABT) || (m == MODE_UND);
    endfunction

    function automatic logic is_valid_mode(input logic [MODE_W-1:0] m);
        return is_exc_mode(m) || (m == MODE_USR) || (m == MODE_SYS);
    endfunction

    function automatic logic [IDX_W-1:0] bank_idx(input logic [MODE_W-1:0] m);
        case (m)
            MODE_IRQ: return IDX_W'(1);
            MODE_SVC: return IDX_W'(2);
            MODE_ABT: return IDX_W'(3);
            MODE_UND: return IDX_W'(4);
            default:  return IDX_W'(0);
        endcase
    endfunction

    logic [NZCV_W-1:0] nzcv_q, nzcv_d;
    logic              i_q, i_d;
    logic              f_q, f_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [SPSR_W-1:0] spsr_q [BANK_N];
    logic [SPSR_W-1:0] spsr_d [BANK_N];

    logic              cur_banked;
    logic [IDX_W-1:0]  cur_idx;
    logic [SPSR_W-1:0] cur_spsr;
    logic [SPSR_W-1:0] cpsr_packed;
    logic              msr_f;
    logic              msr_c;
    logic              unused_msr_bits;

    assign cur_banked  = is_exc_mode(mode_q);
    assign cur_idx     = bank_idx(mode_q);
    assign cur_spsr    = spsr_q[cur_idx];
    assign cpsr_packed = {nzcv_q, i_q, f_q, 1'b0, mode_q};
    assign msr_f       = in_msr_field[1];
    assign msr_c       = in_msr_field[0];

    // Only the f and c byte lanes of the MSR source are architected here.
    assign unused_msr_bits = ^in_msr_data[27:8];

    // Next-state selection; lower-priority requests are dropped, not deferred.
    always_comb begin
        nzcv_d = nzcv_q;
        i_d    = i_q;
        f_d    = f_q;
        mode_d = mode_q;
        for (int b = 0; b < int'(BANK_N); b++) begin
            spsr_d[b] = spsr_q[b];
        end

        if (in_exc_req) begin
            if (is_exc_mode(in_exc_mode)) begin
                spsr_d[bank_idx(in_exc_mode)] = cpsr_packed;
                mode_d = in_exc_mode;
                i_d    = 1'b1;
                if (in_exc_mode == MODE_FIQ) begin
                    f_d = 1'b1;
                end
            end
        end else if (in_exc_return && in_execute_en) begin
            if (cur_banked && is_valid_mode(cur_spsr[MODE_W-1:0])) begin
                nzcv_d = cur_spsr[11:8];
                i_d    = cur_spsr[7];
                f_d    = cur_spsr[6];
                mode_d = cur_spsr[MODE_W-1:0];
            end
        end else if (in_msr_we && in_execute_en) begin
            if (!in_msr_spsr) begin
                if (msr_f) begin
                    nzcv_d = in_msr_data[31:28];
                end
                if (msr_c && (mode_q != MODE_USR)) begin
                    i_d = in_msr_data[7];
                    f_d = in_msr_data[6];
                    if (is_valid_mode(in_msr_data[4:0])) begin
                        mode_d = in_msr_data[4:0];
                    end
                end
            end else if (cur_banked) begin
                if (msr_f) begin
                    spsr_d[cur_idx][11:8] = in_msr_data[31:28];
                end
                if (msr_c) begin
                    spsr_d[cur_idx][7:0] = in_msr_data[7:0];
                end
            end
        end else if (in_flag_we && in_execute_en) begin
            nzcv_d = (nzcv_q & ~in_flag_mask) | (in_alu_flags & in_flag_mask);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            nzcv_q <= '0;
            i_q    <= 1'b1;
            f_q    <= 1'b1;
            mode_q <= MODE_SVC;
            for (int b = 0; b < int'(BANK_N); b++) begin
                spsr_q[b] <= '0;
            end
        end else begin
            nzcv_q <= nzcv_d;
            i_q    <= i_d;
            f_q    <= f_d;
            mode_q <= mode_d;
            for (int b = 0; b < int'(BANK_N); b++) begin
                spsr_q[b] <= spsr_d[b];
            end
        end
    end

    assign out_cpsr  = {nzcv_q, 20'd0, i_q, f_q, 1'b0, mode_q};
    assign out_flags = nzcv_q;
    assign out_priv  = (mode_q != MODE_USR);
    assign out_spsr  = cur_banked ? {cur_spsr[11:8], 20'd0, cur_spsr[7:0]} : 32'd0;

endmodule

// File: doc/cpsr_unit.md
# cpsr_unit

Holds the program status state of the CPU: the current program status register (CPSR) and one saved PSR (SPSR) per exception mode. It sits directly upstream of the conditional evaluator, which takes its `out_flags` as the NZCV input, and downstream of the ALU and decode, which supply flag results, MSR writes, exception entry and exception return. All state changes are registered; the flags the evaluator sees are always the committed CPSR value.

## Interface
- No parameters.
- `in_clk` input 1: clock; all state updates on its rising edge.
- `in_rst_n` input 1: asynchronous reset, active-low.
- `in_execute_en` input 1: from the conditional evaluator; gates flag updates, MSR and exception return.
- `in_flag_we` input 1: S-bit data-processing result valid this cycle.
- `in_alu_flags` input 4: ALU result flags {N,Z,C,V}.
- `in_flag_mask` input 4: per-flag update enable {N,Z,C,V}, for example 4'b1110 for logical ops that preserve V.
- `in_msr_we` input 1: MSR write request.
- `in_msr_spsr` input 1: 0 targets CPSR, 1 targets the SPSR of the current mode.
- `in_msr_field` input 2: {f,c}. f selects bits [31:28] and c selects bits [7:0].
- `in_msr_data` input 32: MSR source value.
- `in_exc_req` input 1: exception entry request; not gated by `in_execute_en`.
- `in_exc_mode` input 5: target mode of the exception.
- `in_exc_return` input 1: restore CPSR from the current SPSR.
- `out_cpsr` output 32: bits 31:28 are NZCV, 7 is I, 6 is F, 5 is T (always 0), 4:0 are the mode. All other bits are 0.
- `out_flags` output 4: `out_cpsr[31:28]`, to the conditional evaluator.
- `out_spsr` output 32: SPSR of the current mode; 0 in USR or SYS.
- `out_priv` output 1: 1 when the mode is not USR.

## Operation
- Mode encodings:
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
  - Any other mode value is invalid.
- Banked SPSRs are held for FIQ, IRQ, SVC, ABT and UND. Each stores bits 31:28 and 7:0; the remaining bits read as 0.
- Event priority, with exactly one event applied per cycle: exc_req, then exc_return, then msr, then flag update. Lower-priority requests in the same cycle are dropped, not deferred.
- **Exception entry** (`in_exc_req`=1 and `in_exc_mode` is one of the five exception modes):
  - SPSR[`in_exc_mode`] <= CPSR.
  - CPSR.mode <= `in_exc_mode` and I <= 1.
  - F <= 1 only when `in_exc_mode` is FIQ.
  - NZCV unchanged.
  - An exc_req with any other mode value is ignored entirely, and lower-priority events do not proceed either.
- **Exception return** (`in_exc_return` and `in_execute_en`): CPSR <= SPSR[current mode].
  - Ignored in USR or SYS.
  - Ignored when the SPSR's mode field is invalid.
- **MSR** (`in_msr_we` and `in_execute_en`):
  - The f field writes NZCV from data[31:28].
  - CPSR target:
    - The c field is ignored in USR.
    - In privileged modes it writes I, F and mode from data[7:6] and data[4:0].
    - The mode part is ignored if invalid; I and F are still written.
  - SPSR target: ignored in USR or SYS. Otherwise the selected fields are written verbatim, with no mode validation.
- **Flag update** (`in_flag_we` and `in_execute_en`): each NZCV bit whose mask bit is 1 takes the corresponding bit of `in_alu_flags`.
- `out_spsr`, `out_priv` and `out_flags` are combinational decodes of the registered state.

## Timing
- Reset state:
  - CPSR = 0x000000D3 (SVC, I=F=1, NZCV=0).
  - All SPSRs = 0.
  - `out_flags`=0, `out_priv`=1, `out_spsr`=0.
- Latency: an event sampled at edge k is visible on all outputs after edge k. There is no bypass, so the evaluator sees new flags one cycle after the setting instruction; the pipeline must interlock.
- Reset asserted mid-operation forces the reset state immediately, regardless of the clock. Requests present at deassertion are applied on the first subsequent edge.
- Simultaneous exc_req and flag update: only the entry happens. The SPSR captures the pre-update flags.
- Outputs are stable throughout a cycle with no request.

## Test plan
- Reset, then one idle cycle: `out_cpsr`=0x000000D3, `out_flags`=0, `out_priv`=1, `out_spsr`=0.
- MSR CPSR c field with data 0x10 from SVC, then flag_we with flags 4'b1111 and mask 4'b1110 (execute_en=1):
  - After the first edge: mode USR, I=F=0, `out_priv`=0.
  - Next cycle: `out_flags`=4'b1110.
  - A further MSR c field with 0x1F in USR leaves the mode at USR.
- From SVC with NZCV=0101, exc_req to IRQ (10010) together with flag_we (flags 1111, mask 1111):
  - `out_cpsr`=0x50000092 and `out_spsr`=0x50000013.
  - Then exc_return with execute_en=1: `out_cpsr`=0x50000013.
- Exc_req with FIQ (10001): F=1 and I=1. Exc_req with mode 10100: no state change.
- Flag_we or MSR with execute_en=0: no change. Exc_return in SYS: no change. MSR to SPSR in USR: no change.
- Assert `in_rst_n` low between edges after several updates: outputs return to the reset values immediately, without waiting for a clock edge.
